cla_serial_adder: RTL and testbench

//  Multi-cycle WIDTH-bit adder built around one cla4_aug (4-bit CLA, s/pout/gout).

---
 rtl/cla_serial_adder_pkg.sv | 14 +
 rtl/cla_serial_adder_cla4_aug.sv | 39 +++
 rtl/cla_serial_adder.sv | 153 +++++++++++++++
 tb/tb_cla_serial_adder.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cla_serial_adder_pkg.sv
// Shared definitions for the nibble-serial CLA adder.
//   state_e : FSM state encoding (the unused code 2'd3 is treated as IDLE)
//   NIB_W   : width of one CLA slice / one serial step
package cla_serial_adder_pkg;

    localparam int unsigned NIB_W = 4;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/cla_serial_adder_cla4_aug.sv
// cla4_aug: 4-bit carry-lookahead slice with group propagate/generate.
//   a, b  : 4-bit operand nibbles
//   cin   : carry into bit 0
//   s     : 4-bit sum
//   pout  : group propagate (all four bits propagate)
//   gout  : group generate (a carry is produced inside the nibble)
// The slice does not expose its own carry-out; callers form it from pout/gout.
module cla4_aug
    import cla_serial_adder_pkg::*;
(
    input  logic [NIB_W-1:0] a,
    input  logic [NIB_W-1:0] b,
    input  logic             cin,
    output logic [NIB_W-1:0] s,
    output logic             pout,
    output logic             gout
);

    logic [NIB_W-1:0] p;
    logic [NIB_W-1:0] g;
    logic [NIB_W-1:0] c;

    always_comb begin
        p = a ^ b;
        g = a & b;

        c[0] = cin;
        c[1] = g[0] | (p[0] & cin);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
             | (p[2] & p[1] & p[0] & cin);

        s    = p ^ c;
        pout = &p;
        gout = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
             | (p[3] & p[2] & p[1] & g[0]);
    end

endmodule

// File: rtl/cla_serial_adder.sv
// cla_serial_adder: WIDTH-bit adder that reuses one cla4_aug slice, one
// nibble per cycle, LSB nibble first.
//   clk, rst : clock (rising edge), asynchronous active-high reset
//   start    : request, accepted only in IDLE or DONE
//   a, b     : operands, captured on accept
//   cin      : carry-in, captured on accept
//   busy     : high while nibbles are being processed
//   done     : one-cycle pulse when sum/cout/ovf are valid
//   sum      : result, held until the next accepted start
//   cout     : carry out of bit WIDTH-1
//   ovf      : two's-complement overflow
module cla_serial_adder
    import cla_serial_adder_pkg::*;
#(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int unsigned NNIB  = WIDTH / NIB_W;
    localparam int unsigned IDX_W = $clog2(NNIB);

    if ((WIDTH % NIB_W) != 0 || WIDTH < 8) begin : g_bad_width
        $error("cla_serial_adder: WIDTH must be a multiple of 4 and >= 8");
    end

    state_e             state_q,  state_d;
    logic [IDX_W-1:0]   idx_q,    idx_d;
    logic [WIDTH-1:0]   op_a_q,   op_a_d;
    logic [WIDTH-1:0]   op_b_q,   op_b_d;
    logic               carry_q,  carry_d;
    logic               busy_q,   busy_d;
    logic               done_q,   done_d;
    logic [WIDTH-1:0]   sum_q,    sum_d;
    logic               cout_q,   cout_d;
    logic               ovf_q,    ovf_d;

    logic [NIB_W-1:0]   nib_a;
    logic [NIB_W-1:0]   nib_b;
    logic [NIB_W-1:0]   nib_s;
    logic               nib_p;
    logic               nib_g;
    logic               carry_nxt;
    logic               last_nib;
    logic               c_msb;
    logic               accept;

    cla4_aug u_cla4 (
        .a    (nib_a),
        .b    (nib_b),
        .cin  (carry_q),
        .s    (nib_s),
        .pout (nib_p),
        .gout (nib_g)
    );

    always_comb begin
        nib_a     = op_a_q[idx_q*NIB_W +: NIB_W];
        nib_b     = op_b_q[idx_q*NIB_W +: NIB_W];
        carry_nxt = nib_g | (nib_p & carry_q);
        last_nib  = (idx_q == IDX_W'(NNIB - 1));
        // Carry into the MSB recovered from the MSB sum bit being written now.
        c_msb     = op_a_q[WIDTH-1] ^ op_b_q[WIDTH-1] ^ nib_s[NIB_W-1];
        accept    = 1'b0;

        state_d = state_q;
        idx_d   = idx_q;
        op_a_d  = op_a_q;
        op_b_d  = op_b_q;
        carry_d = carry_q;
        busy_d  = 1'b0;
        done_d  = 1'b0;
        sum_d   = sum_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;

        case (state_q)
            S_RUN: begin
                sum_d[idx_q*NIB_W +: NIB_W] = nib_s;
                carry_d = carry_nxt;
                if (last_nib) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                    cout_d  = carry_nxt;
                    ovf_d   = c_msb ^ carry_nxt;
                end else begin
                    idx_d   = idx_q + 1'b1;
                    busy_d  = 1'b1;
                end
            end
            S_DONE: begin
                accept  = start;
                state_d = S_IDLE;
            end
            default: begin
                accept  = start;
                state_d = S_IDLE;
            end
        endcase

        if (accept) begin
            state_d = S_RUN;
            op_a_d  = a;
            op_b_d  = b;
            carry_d = cin;
            idx_d   = '0;
            busy_d  = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            op_a_q  <= '0;
            op_b_q  <= '0;
            carry_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            op_a_q  <= op_a_d;
            op_b_q  <= op_b_d;
            carry_q <= carry_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign sum  = sum_q;
    assign cout = cout_q;
    assign ovf  = ovf_q;

endmodule

// File: tb/tb_cla_serial_adder.sv
module tb_cla_serial_adder;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic        start16 = 1'b0;
    logic [15:0] a16 = '0;
    logic [15:0] b16 = '0;
    logic        cin16 = 1'b0;
    logic        busy16, done16, cout16, ovf16;
    logic [15:0] sum16;

    logic        start32 = 1'b0;
    logic [31:0] a32 = '0;
    logic [31:0] b32 = '0;
    logic        cin32 = 1'b0;
    logic        busy32, done32, cout32, ovf32;
    logic [31:0] sum32;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    cla_serial_adder #(.WIDTH(16)) dut16 (
        .clk(clk), .rst(rst), .start(start16), .a(a16), .b(b16), .cin(cin16),
        .busy(busy16), .done(done16), .sum(sum16), .cout(cout16), .ovf(ovf16)
    );

    cla_serial_adder #(.WIDTH(32)) dut32 (
        .clk(clk), .rst(rst), .start(start32), .a(a32), .b(b32), .cin(cin32),
        .busy(busy32), .done(done32), .sum(sum32), .cout(cout32), .ovf(ovf32)
    );

    // Present one request for one edge, then count edges (from the accept
    // edge) until done is seen. lat=1 means done right after the accept edge.
    task automatic run_add16(input logic [15:0] av, input logic [15:0] bv,
                             input logic cv, output int lat);
        @(posedge clk); #1;
        a16 = av; b16 = bv; cin16 = cv; start16 = 1'b1;
        @(posedge clk); #1;
        start16 = 1'b0;
        lat = 1;
        while (done16 !== 1'b1 && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic run_add32(input logic [31:0] av, input logic [31:0] bv,
                             input logic cv, output int lat);
        @(posedge clk); #1;
        a32 = av; b32 = bv; cin32 = cv; start32 = 1'b1;
        @(posedge clk); #1;
        start32 = 1'b0;
        lat = 1;
        while (done32 !== 1'b1 && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({busy16, done16, sum16, cout16, ovf16} !== 20'h0) begin
            errors++;
            $display("FAIL reset_outputs: got busy=%b done=%b sum=%h cout=%b ovf=%b, want all 0",
                     busy16, done16, sum16, cout16, ovf16);
        end
        rst = 1'b0;
    endtask

    task automatic test_basic();
        int lat;
        // Check busy right after accept
        @(posedge clk); #1;
        a16 = 16'd7; b16 = 16'd8; cin16 = 1'b0; start16 = 1'b1;
        @(posedge clk); #1;
        start16 = 1'b0;
        checks++;
        if (busy16 !== 1'b1) begin
            errors++;
            $display("FAIL basic_busy: got %b want 1", busy16);
        end
        lat = 1;
        while (done16 !== 1'b1 && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        checks++;
        if (lat !== 5) begin
            errors++;
            $display("FAIL basic_latency: got %0d want 5", lat);
        end
        checks++;
        if ({cout16, ovf16, sum16} !== {1'b0, 1'b0, 16'h000F}) begin
            errors++;
            $display("FAIL basic_result: got sum=%h cout=%b ovf=%b want 000f 0 0",
                     sum16, cout16, ovf16);
        end
        checks++;
        if (busy16 !== 1'b0) begin
            errors++;
            $display("FAIL basic_busy_done: got %b want 0", busy16);
        end
        @(posedge clk); #1;
        checks++;
        if (done16 !== 1'b0 || sum16 !== 16'h000F) begin
            errors++;
            $display("FAIL basic_pulse_hold: got done=%b sum=%h want 0 000f", done16, sum16);
        end
    endtask

    task automatic test_carry_ripple();
        int lat;
        run_add16(16'hFFFF, 16'h0001, 1'b0, lat);
        checks++;
        if ({cout16, ovf16, sum16} !== {1'b1, 1'b0, 16'h0000} || lat !== 5) begin
            errors++;
            $display("FAIL ripple: got sum=%h cout=%b ovf=%b lat=%0d want 0000 1 0 5",
                     sum16, cout16, ovf16, lat);
        end
    endtask

    task automatic test_overflow();
        int lat;
        run_add16(16'h7FFF, 16'h0001, 1'b0, lat);
        checks++;
        if ({cout16, ovf16, sum16} !== {1'b0, 1'b1, 16'h8000}) begin
            errors++;
            $display("FAIL ovf_pos: got sum=%h cout=%b ovf=%b want 8000 0 1",
                     sum16, cout16, ovf16);
        end
        run_add16(16'h8000, 16'h8000, 1'b0, lat);
        checks++;
        if ({cout16, ovf16, sum16} !== {1'b1, 1'b1, 16'h0000}) begin
            errors++;
            $display("FAIL ovf_neg: got sum=%h cout=%b ovf=%b want 0000 1 1",
                     sum16, cout16, ovf16);
        end
        run_add16(16'hFFFF, 16'hFFFF, 1'b1, lat);
        checks++;
        if ({cout16, ovf16, sum16} !== {1'b1, 1'b0, 16'hFFFF}) begin
            errors++;
            $display("FAIL cin_all_ones: got sum=%h cout=%b ovf=%b want ffff 1 0",
                     sum16, cout16, ovf16);
        end
    endtask

    task automatic test_back_to_back();
        int lat;
        @(posedge clk); #1;
        a16 = 16'h1234; b16 = 16'h1111; cin16 = 1'b1; start16 = 1'b1;
        @(posedge clk); #1;              // accept edge; 1st RUN cycle
        start16 = 1'b0;
        @(posedge clk); #1;              // 2nd RUN cycle: start must be ignored
        a16 = 16'hFFFF; b16 = 16'hFFFF; start16 = 1'b1;
        @(posedge clk); #1;
        start16 = 1'b0;
        checks++;
        if (busy16 !== 1'b1 || done16 !== 1'b0) begin
            errors++;
            $display("FAIL b2b_ignore_busy: got busy=%b done=%b want 1 0", busy16, done16);
        end
        lat = 3;
        while (done16 !== 1'b1 && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        checks++;
        if (sum16 !== 16'h2346 || cout16 !== 1'b0 || lat !== 5) begin
            errors++;
            $display("FAIL b2b_first: got sum=%h cout=%b lat=%0d want 2346 0 5",
                     sum16, cout16, lat);
        end
        // Start during the DONE cycle
        a16 = 16'h0F0F; b16 = 16'h00F1; cin16 = 1'b0; start16 = 1'b1;
        @(posedge clk); #1;
        start16 = 1'b0;
        a16 = 16'hAAAA; b16 = 16'h5555;
        checks++;
        if (busy16 !== 1'b1 || done16 !== 1'b0) begin
            errors++;
            $display("FAIL b2b_no_bubble: got busy=%b done=%b want 1 0", busy16, done16);
        end
        lat = 1;
        while (done16 !== 1'b1 && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        checks++;
        if (sum16 !== 16'h1000 || cout16 !== 1'b0 || ovf16 !== 1'b0 || lat !== 5) begin
            errors++;
            $display("FAIL b2b_second: got sum=%h cout=%b ovf=%b lat=%0d want 1000 0 0 5",
                     sum16, cout16, ovf16, lat);
        end
    endtask

    task automatic test_mid_reset();
        int lat;
        int seen_done;
        @(posedge clk); #1;
        a16 = 16'h1111; b16 = 16'h2222; cin16 = 1'b0; start16 = 1'b1;
        @(posedge clk); #1;              // 1st RUN cycle
        start16 = 1'b0;
        @(posedge clk); #1;              // 2nd RUN cycle
        @(posedge clk); #1;              // 3rd RUN cycle
        checks++;
        if (sum16[7:0] !== 8'h33 || busy16 !== 1'b1) begin
            errors++;
            $display("FAIL midrst_pre: got sum=%h busy=%b want low byte 33 busy 1", sum16, busy16);
        end
        #1 rst = 1'b1;
        #1;
        checks++;
        if ({busy16, done16, sum16, cout16, ovf16} !== 20'h0) begin
            errors++;
            $display("FAIL midrst_clear: got busy=%b done=%b sum=%h cout=%b ovf=%b want all 0",
                     busy16, done16, sum16, cout16, ovf16);
        end
        #2 rst = 1'b0;
        seen_done = 0;
        repeat (8) begin
            @(posedge clk); #1;
            if (done16 === 1'b1 || busy16 === 1'b1) seen_done++;
        end
        checks++;
        if (seen_done !== 0) begin
            errors++;
            $display("FAIL midrst_no_done: got %0d active cycles want 0", seen_done);
        end
        run_add16(16'd5, 16'd9, 1'b0, lat);
        checks++;
        if (sum16 !== 16'h000E || cout16 !== 1'b0 || ovf16 !== 1'b0 || lat !== 5) begin
            errors++;
            $display("FAIL midrst_fresh: got sum=%h cout=%b ovf=%b lat=%0d want 000e 0 0 5",
                     sum16, cout16, ovf16, lat);
        end
    endtask

    task automatic test_sweep32();
        int lat;
        logic [31:0] ra;
        logic [31:0] rb;
        logic        rc;
        logic [32:0] exp_sum;
        logic        exp_ovf;
        for (int i = 0; i < 1000; i++) begin
            ra = $urandom;
            rb = $urandom;
            rc = 1'($urandom_range(0, 1));
            if (i == 0) begin ra = 32'h7FFFFFFF; rb = 32'h0; rc = 1'b1; end
            if (i == 1) begin ra = 32'hFFFFFFFF; rb = 32'h0; rc = 1'b1; end
            exp_sum = {1'b0, ra} + {1'b0, rb} + {32'h0, rc};
            exp_ovf = (ra[31] == rb[31]) && (exp_sum[31] != ra[31]);
            run_add32(ra, rb, rc, lat);
            checks++;
            if ({cout32, sum32} !== exp_sum || ovf32 !== exp_ovf || lat !== 9) begin
                errors++;
                $display("FAIL sweep32[%0d]: a=%h b=%h cin=%b got cout=%b sum=%h ovf=%b lat=%0d want cout=%b sum=%h ovf=%b lat=9",
                         i, ra, rb, rc, cout32, sum32, ovf32, lat,
                         exp_sum[32], exp_sum[31:0], exp_ovf);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_carry_ripple();
        test_overflow();
        test_back_to_back();
        test_mid_reset();
        test_sweep32();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
